// File: rtl/walk_signal_ctrl_pkg.sv
// walk_signal_ctrl_pkg: crossing phase encodings and default timing constants
package walk_signal_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WALK  = 3'd2,
    S_FLASH = 3'd3,
    S_HOLD  = 3'd4
  } phase_e;
  localparam int WALK_TICKS_DEF  = 8;
  localparam int FLASH_TICKS_DEF = 5;
  localparam int CW_DEF          = 4;
endpackage

// File: rtl/walk_signal_ctrl_phase_fsm.sv
// walk_signal_ctrl_phase_fsm: one crossing - button sync, request latch, phase FSM, countdown, lamps
module walk_signal_ctrl_phase_fsm
  import walk_signal_ctrl_pkg::*;
#(
  parameter int WALK_TICKS  = WALK_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          green,
  input  logic          btn,
  input  logic          force_idle,
  output logic          walk,
  output logic          flash,
  output logic          dont_walk,
  output logic [CW-1:0] count
);
  phase_e        state, state_n;
  logic [2:0]    sync;
  logic          req, green_d, btn_rise, green_rise, last, entry, flash_n;
  logic [CW-1:0] cnt, cnt_n, dec;
  assign btn_rise   = sync[1] & ~sync[2];
  assign green_rise = green & ~green_d;
  assign dec        = (cnt == '0) ? '0 : cnt - 1'b1;
  // the phase ends on the tick that drains the counter, so Count never shows 0 in FLASH
  assign last       = tick && (cnt <= CW'(1));
  assign entry      = state_n != state;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = req ? S_WAIT : S_IDLE;
      S_WAIT:  state_n = green_rise ? S_WALK : S_WAIT;
      S_WALK:  state_n = !green ? (req ? S_WAIT : S_IDLE) : last ? S_FLASH : S_WALK;
      S_FLASH: state_n = !green ? (req ? S_WAIT : S_IDLE) : last ? S_HOLD : S_FLASH;
      S_HOLD:  state_n = !green ? (req ? S_WAIT : S_IDLE) : S_HOLD;
      default: state_n = S_IDLE;
    endcase
    if (force_idle) state_n = S_IDLE;
  end
  // a tick landing on a state entry only loads the counter
  assign cnt_n   = entry ? (state_n == S_WALK ? CW'(WALK_TICKS) : state_n == S_FLASH ? CW'(FLASH_TICKS) : '0)
                         : (tick ? dec : cnt);
  assign flash_n = (state_n != S_FLASH) ? 1'b0 : (state != S_FLASH) ? 1'b1 : flash ^ tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sync      <= '0;
      req       <= 1'b0;
      green_d   <= 1'b0;
      cnt       <= '0;
      walk      <= 1'b0;
      flash     <= 1'b0;
      dont_walk <= 1'b1;
      count     <= '0;
    end else begin
      state     <= state_n;
      sync      <= {sync[1:0], btn};
      req       <= (req & ~(entry && state_n == S_WALK)) | btn_rise;
      green_d   <= green;
      cnt       <= cnt_n;
      walk      <= state_n == S_WALK;
      flash     <= flash_n;
      dont_walk <= state_n != S_WALK && state_n != S_FLASH;
      count     <= (state_n == S_FLASH) ? cnt_n : '0;
    end
  end
endmodule

// File: rtl/walk_signal_ctrl.sv
// walk_signal_ctrl: two pedestrian crossings slaved to the lane greens, with sticky conflict fault
module walk_signal_ctrl
  import walk_signal_ctrl_pkg::*;
#(
  parameter int WALK_TICKS  = WALK_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          lane12,
  input  logic          lane34,
  input  logic          ped12_btn,
  input  logic          ped34_btn,
  output logic          walk12,
  output logic          flash12,
  output logic          dont_walk12,
  output logic [CW-1:0] count12,
  output logic          walk34,
  output logic          flash34,
  output logic          dont_walk34,
  output logic [CW-1:0] count34,
  output logic          fault
);
  logic lane12_q, lane34_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane12_q <= 1'b0;
      lane34_q <= 1'b0;
      fault    <= 1'b0;
    end else begin
      lane12_q <= lane12;
      lane34_q <= lane34;
      fault    <= fault | (lane12_q & lane34_q);
    end
  end
  walk_signal_ctrl_phase_fsm #(.WALK_TICKS(WALK_TICKS), .FLASH_TICKS(FLASH_TICKS), .CW(CW)) u_x12 (
    .clk(clk), .rst(rst), .tick(tick), .green(lane12_q), .btn(ped12_btn), .force_idle(fault),
    .walk(walk12), .flash(flash12), .dont_walk(dont_walk12), .count(count12)
  );
  walk_signal_ctrl_phase_fsm #(.WALK_TICKS(WALK_TICKS), .FLASH_TICKS(FLASH_TICKS), .CW(CW)) u_x34 (
    .clk(clk), .rst(rst), .tick(tick), .green(lane34_q), .btn(ped34_btn), .force_idle(fault),
    .walk(walk34), .flash(flash34), .dont_walk(dont_walk34), .count(count34)
  );
endmodule

// File: tb/tb_walk_signal_ctrl.sv
// tb_walk_signal_ctrl: table-driven vectors with an expected-result queue, plus async reset sequences
module tb_walk_signal_ctrl;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, lane12 = 1'b0, lane34 = 1'b0, ped12_btn = 1'b0, ped34_btn = 1'b0;
  logic walk12, flash12, dont_walk12, walk34, flash34, dont_walk34, fault;
  logic [3:0] count12, count34;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  walk_signal_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .lane12(lane12), .lane34(lane34),
    .ped12_btn(ped12_btn), .ped34_btn(ped34_btn),
    .walk12(walk12), .flash12(flash12), .dont_walk12(dont_walk12), .count12(count12),
    .walk34(walk34), .flash34(flash34), .dont_walk34(dont_walk34), .count34(count34),
    .fault(fault)
  );
  typedef struct packed {
    logic [127:0] name;
    logic         tk, l12, l34, b12, b34;
    int           n;
    logic [6:0]   e12, e34;
    logic         flt;
  } vec_t;
  localparam logic [6:0] DW = 7'h10;
  localparam logic [6:0] WK = 7'h40;
  vec_t       vecs[$];
  logic [14:0] exp_q[$];
  function automatic logic [6:0] fl(logic f, logic [3:0] c);
    return {1'b0, f, 1'b0, c};
  endfunction
  function automatic vec_t mk(logic [127:0] name, logic tk, logic l12, logic l34, logic b12, logic b34,
                              int n, logic [6:0] e12, logic [6:0] e34, logic flt);
    vec_t v;
    v.name = name; v.tk = tk; v.l12 = l12; v.l34 = l34; v.b12 = b12; v.b34 = b34;
    v.n = n; v.e12 = e12; v.e34 = e34; v.flt = flt;
    return v;
  endfunction
  function automatic logic [14:0] got();
    return {walk12, flash12, dont_walk12, count12, walk34, flash34, dont_walk34, count34, fault};
  endfunction
  task automatic check(input logic [127:0] name, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %0s: got w/f/dw/c12=%b%b%b/%0d w/f/dw/c34=%b%b%b/%0d fault=%b, expected w/f/dw/c12=%b%b%b/%0d w/f/dw/c34=%b%b%b/%0d fault=%b",
               name, act[14], act[13], act[12], act[11:8], act[7], act[6], act[5], act[4:1], act[0],
               exp[14], exp[13], exp[12], exp[11:8], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask
  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      tick = (i == 0) && v.tk;
      lane12 = v.l12; lane34 = v.l34; ped12_btn = v.b12; ped34_btn = v.b34;
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    exp_q.push_back({v.e12, v.e34, v.flt});
    @(negedge clk);
    check(v.name, got(), exp_q.pop_front());
  endtask
  task automatic request12();
    run_vec(mk("b12_press", 0, 0, 0, 1, 0, 5, DW, DW, 0));
    run_vec(mk("b12_release", 0, 0, 0, 0, 0, 2, DW, DW, 0));
  endtask
  initial begin
    // full cycle on crossing 12
    vecs.push_back(mk("reset_idle", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    vecs.push_back(mk("b12_press", 0, 0, 0, 1, 0, 5, DW, DW, 0));
    vecs.push_back(mk("b12_release", 0, 0, 0, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("g12_rise_walk", 0, 1, 0, 0, 0, 3, WK, DW, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk("walk12_tick", 1, 1, 0, 0, 0, 2, WK, DW, 0));
    vecs.push_back(mk("flash12_5", 1, 1, 0, 0, 0, 2, fl(1, 5), DW, 0));
    for (int c = 4; c >= 1; c--) vecs.push_back(mk("flash12_count", 1, 1, 0, 0, 0, 2, fl(c[0], 4'(c)), DW, 0));
    vecs.push_back(mk("hold12", 1, 1, 0, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("hold12_stay", 0, 1, 0, 0, 0, 3, DW, DW, 0));
    vecs.push_back(mk("g12_fall_idle", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    // request during green on crossing 34 waits for the next rise
    vecs.push_back(mk("g34_no_req", 0, 0, 1, 0, 0, 3, DW, DW, 0));
    vecs.push_back(mk("b34_mid_green", 0, 0, 1, 0, 1, 5, DW, DW, 0));
    vecs.push_back(mk("b34_release", 0, 0, 1, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("b34_no_short", 1, 0, 1, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("g34_off", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    vecs.push_back(mk("g34_rise_walk", 0, 0, 1, 0, 0, 3, DW, WK, 0));
    vecs.push_back(mk("walk34_tick", 1, 0, 1, 0, 0, 2, DW, WK, 0));
    vecs.push_back(mk("g34_fall_walk", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    // lane 12 drops mid-FLASH
    vecs.push_back(mk("b12_press", 0, 0, 0, 1, 0, 5, DW, DW, 0));
    vecs.push_back(mk("b12_release", 0, 0, 0, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("g12_rise_walk", 0, 1, 0, 0, 0, 3, WK, DW, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk("walk12_tick", 1, 1, 0, 0, 0, 2, WK, DW, 0));
    vecs.push_back(mk("flash12_5", 1, 1, 0, 0, 0, 2, fl(1, 5), DW, 0));
    vecs.push_back(mk("flash12_4", 1, 1, 0, 0, 0, 2, fl(0, 4), DW, 0));
    vecs.push_back(mk("flash12_3", 1, 1, 0, 0, 0, 2, fl(1, 3), DW, 0));
    vecs.push_back(mk("fall12_lane_reg", 0, 0, 0, 0, 0, 1, fl(1, 3), DW, 0));
    vecs.push_back(mk("fall12_abort", 0, 0, 0, 0, 0, 1, DW, DW, 0));
    // tick coincident with WALK entry
    vecs.push_back(mk("b12_press", 0, 0, 0, 1, 0, 5, DW, DW, 0));
    vecs.push_back(mk("b12_release", 0, 0, 0, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("g12_pre_entry", 0, 1, 0, 0, 0, 1, DW, DW, 0));
    vecs.push_back(mk("entry_tick", 1, 1, 0, 0, 0, 1, WK, DW, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk("entry_walk_tick", 1, 1, 0, 0, 0, 2, WK, DW, 0));
    vecs.push_back(mk("entry_flash_5", 1, 1, 0, 0, 0, 2, fl(1, 5), DW, 0));
    vecs.push_back(mk("g12_fall_flash", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    // lane conflict while crossing 12 walks
    vecs.push_back(mk("b12_press", 0, 0, 0, 1, 0, 5, DW, DW, 0));
    vecs.push_back(mk("b12_release", 0, 0, 0, 0, 0, 2, DW, DW, 0));
    vecs.push_back(mk("g12_rise_walk", 0, 1, 0, 0, 0, 3, WK, DW, 0));
    vecs.push_back(mk("both_lane_reg", 0, 1, 1, 0, 0, 1, WK, DW, 0));
    vecs.push_back(mk("fault_set", 0, 1, 1, 0, 0, 2, DW, DW, 1));
    vecs.push_back(mk("fault_sticky", 1, 1, 0, 0, 0, 3, DW, DW, 1));
    vecs.push_back(mk("fault_b34", 0, 0, 0, 0, 1, 5, DW, DW, 1));
    vecs.push_back(mk("fault_g34", 1, 0, 1, 0, 0, 3, DW, DW, 1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);
    // async reset clears the sticky fault immediately
    #2 rst = 1'b1;
    #1 check("rst_clears_fault", got(), {DW, DW, 1'b0});
    lane12 = 1'b0; lane34 = 1'b0; ped34_btn = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    // reset pulse in the middle of WALK aborts at once
    request12();
    run_vec(mk("pre_rst_walk", 0, 1, 0, 0, 0, 3, WK, DW, 0));
    run_vec(mk("pre_rst_tick", 1, 1, 0, 0, 0, 2, WK, DW, 0));
    #2 rst = 1'b1;
    #1 check("rst_mid_walk", got(), {DW, DW, 1'b0});
    lane12 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_vec(mk("post_rst_idle", 0, 0, 0, 0, 0, 3, DW, DW, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
